relu_maxpool2x2_stream: RTL and testbench

//  Downstream stage of the conv engine: consumes the serial fp16 conv output stream (raster order,
//  one pixel per in_valid), applies ReLU, then 2x2 stride-2 max pooling with a half-width line buffer.

---
 rtl/relu_maxpool2x2_stream_if.sv | 28 ++
 rtl/relu_maxpool2x2_stream.sv | 174 +++++++++++++++++
 tb/tb_relu_maxpool2x2_stream.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool2x2_stream_if.sv
// Stream bundle for relu_maxpool2x2_stream.
//   master : the producer side. It drives in_valid/in_data/in_last and observes
//            out_valid/out_data/out_addr/out_last.
//   slave  : the pooling stage. It consumes the conv pixel stream and drives the
//            pooled output stream.
// No backpressure in either direction: a valid is a one-cycle transfer.
interface relu_maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 13
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last,
    input  out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/relu_maxpool2x2_stream.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order fp16 pixel stream.
// A half-width line buffer holds the horizontal pair maxima of each even row.
// Those maxima are combined with the pair maxima of the following odd row.
// Pooled pixels leave with a sequential feature-map address.
// Ports:
//   clk_1      clock
//   reset      asynchronous, active-low reset
//   bus        stream interface (slave): in_valid/in_data/in_last in;
//              out_valid/out_data/out_addr/out_last out (registered, 1-cycle pulses)
//   err_clr    synchronous clear of err_frame
//   frame_done 1-cycle pulse, the cycle after the final input pixel of a frame
//   err_frame  sticky flag: in_last did not coincide with the final pixel
module relu_maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int MAP_W      = 84,
  parameter int MAP_H      = 84,
  parameter int ADDR_W     = 13
) (
  input  logic                        clk_1,
  input  logic                        reset,
  relu_maxpool2x2_stream_if.slave     bus,
  input  logic                        err_clr,
  output logic                        frame_done,
  output logic                        err_frame
);

  localparam int HALF_W = MAP_W / 2;
  localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int TOTAL  = (MAP_W / 2) * (MAP_H / 2);

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(MAP_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0]     addr_cnt_q, addr_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  err_frame_q, err_frame_d;

  logic [DATA_WIDTH-1:0] lbuf_q [HALF_W];
  logic                  lbuf_we;
  logic [LB_AW-1:0]      lbuf_idx;
  logic [DATA_WIDTH-1:0] lbuf_wdata;

  logic [DATA_WIDTH-1:0] pix_relu;
  logic                  is_final;
  logic                  odd_row;
  logic                  err_set;

  // Negative values and NaNs clamp to +0. +Inf passes through unchanged.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    if (x[15])                             return '0;
    if ((x[14:10] == 5'h1F) && (x[9:0] != 10'd0)) return '0;
    return x;
  endfunction

  // After ReLU every operand is a non-negative fp16 value.
  // For those, the raw bit patterns order the same way as the numbers they encode.
  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign pix_relu = relu(bus.in_data);
  assign is_final = (row_q == ROW_MAX) && (col_q == COL_MAX);
  assign odd_row  = (state_q == ODD_ROW);
  assign lbuf_idx = LB_AW'(col_q >> 1);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    addr_cnt_d  = addr_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = 1'b0;
    lbuf_we     = 1'b0;
    lbuf_wdata  = max2(hold_q, pix_relu);
    err_set     = 1'b0;

    if (state_q == DONE) state_d = IDLE;

    if (bus.in_valid) begin
      if (bus.in_last && !is_final) begin
        // Premature end of frame: discard the pixel and restart at (0,0).
        err_set    = 1'b1;
        col_d      = '0;
        row_d      = '0;
        addr_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        if (is_final && !bus.in_last) err_set = 1'b1;

        if (!col_q[0]) begin
          hold_d = pix_relu;
        end else if (!odd_row) begin
          lbuf_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = max2(lbuf_q[lbuf_idx], max2(hold_q, pix_relu));
          out_addr_d  = addr_cnt_q;
          out_last_d  = (addr_cnt_q == ADDR_MAX);
          addr_cnt_d  = (addr_cnt_q == ADDR_MAX) ? '0 : addr_cnt_q + ADDR_W'(1);
        end

        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = is_final ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end

        // IDLE and DONE are only ever left at pixel (0,0), so they process as an even row.
        if (is_final)              state_d = DONE;
        else if (col_q == COL_MAX) state_d = odd_row ? EVEN_ROW : ODD_ROW;
        else                       state_d = odd_row ? ODD_ROW : EVEN_ROW;
      end
    end

    // A new error takes precedence over a simultaneous clear.
    err_frame_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_frame_q);
  end

  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      addr_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      addr_cnt_q  <= addr_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      err_frame_q <= err_frame_d;
    end
  end

  // The line buffer has no reset. It is written during even rows and read during odd rows.
  always_ff @(posedge clk_1) begin
    if (lbuf_we) lbuf_q[lbuf_idx] <= lbuf_wdata;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign frame_done    = (state_q == DONE);
  assign err_frame     = err_frame_q;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
module tb_relu_maxpool2x2_stream;

  typedef struct packed {
    logic [15:0] data;
    logic [12:0] addr;
    logic        last;
  } exp_t;

  logic clk_1 = 1'b0;
  logic reset = 1'b0;
  logic err_clr_s = 1'b0;
  logic err_clr_b = 1'b0;
  logic frame_done_s, err_frame_s, frame_done_b, err_frame_b;

  int errors = 0;
  int checks = 0;

  exp_t q_s[$];
  exp_t q_b[$];

  localparam logic [15:0] FP [16] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                      16'h4500, 16'h4600, 16'h4700, 16'h4800,
                                      16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                                      16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
  localparam logic [15:0] T1 [4] = '{16'h4600, 16'h4800, 16'h4B00, 16'h4C00};

  relu_maxpool2x2_stream_if #(.DATA_WIDTH(16), .ADDR_W(13)) bus_s ();
  relu_maxpool2x2_stream_if #(.DATA_WIDTH(16), .ADDR_W(13)) bus_b ();

  relu_maxpool2x2_stream #(.DATA_WIDTH(16), .MAP_W(4), .MAP_H(4), .ADDR_W(13)) dut_s (
    .clk_1(clk_1), .reset(reset), .bus(bus_s.slave), .err_clr(err_clr_s),
    .frame_done(frame_done_s), .err_frame(err_frame_s)
  );

  relu_maxpool2x2_stream #(.DATA_WIDTH(16), .MAP_W(84), .MAP_H(84), .ADDR_W(13)) dut_b (
    .clk_1(clk_1), .reset(reset), .bus(bus_b.slave), .err_clr(err_clr_b),
    .frame_done(frame_done_b), .err_frame(err_frame_b)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk_1) begin
    if (bus_s.out_valid === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected_output actual=0x%0h@%0d required=none",
                 bus_s.out_data, bus_s.out_addr);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        chk("small_data", 32'(bus_s.out_data), 32'(e.data));
        chk("small_addr", 32'(bus_s.out_addr), 32'(e.addr));
        chk("small_last", 32'(bus_s.out_last), 32'(e.last));
      end
    end
    if (bus_b.out_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL big_unexpected_output actual=0x%0h@%0d required=none",
                 bus_b.out_data, bus_b.out_addr);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("big_data", 32'(bus_b.out_data), 32'(e.data));
        chk("big_addr", 32'(bus_b.out_addr), 32'(e.addr));
        chk("big_last", 32'(bus_b.out_last), 32'(e.last));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1); #1;
    end
  endtask

  task automatic send_s(input logic [15:0] d, input logic last);
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = d;
    bus_s.in_last  = last;
    @(posedge clk_1); #1;
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic last);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    bus_b.in_last  = last;
    @(posedge clk_1); #1;
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
  endtask

  task automatic push_t1();
    for (int k = 0; k < 4; k++) q_s.push_back(exp_t'{data: T1[k], addr: 13'(k), last: (k == 3)});
  endtask

  task automatic frame_t1(input bit bubbles);
    for (int i = 0; i < 16; i++) begin
      send_s(FP[i], i == 15);
      if (bubbles && i != 15) idle($urandom_range(0, 3));
    end
  endtask

  function automatic logic [15:0] relu_m(input logic [15:0] x);
    if (x[15]) return 16'h0000;
    if (x[14:10] == 5'h1F && x[9:0] != 10'd0) return 16'h0000;
    return x;
  endfunction

  logic [15:0] fr [84*84];

  initial begin
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0;
    idle(3);
    chk("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus_s.out_data), 32'd0);
    chk("rst_out_addr", 32'(bus_s.out_addr), 32'd0);
    chk("rst_out_last", 32'(bus_s.out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done_s), 32'd0);
    chk("rst_err_frame", 32'(err_frame_s), 32'd0);
    reset = 1'b1;
    idle(2);

    // 1: ramp 1.0..16.0
    push_t1();
    frame_t1(1'b0);
    chk("t1_frame_done", 32'(frame_done_s), 32'd1);
    chk("t1_err_frame", 32'(err_frame_s), 32'd0);
    idle(1);
    chk("t1_frame_done_pulse", 32'(frame_done_s), 32'd0);
    idle(3);

    // 2: negatives and a NaN all clamp to zero
    for (int k = 0; k < 4; k++) q_s.push_back(exp_t'{data: 16'h0000, addr: 13'(k), last: (k == 3)});
    for (int i = 1; i <= 16; i++) send_s((i == 6) ? 16'h7E00 : 16'hBC00, i == 16);
    chk("t2_frame_done", 32'(frame_done_s), 32'd1);
    idle(3);

    // 3: ramp with random bubbles
    push_t1();
    frame_t1(1'b1);
    chk("t3_frame_done", 32'(frame_done_s), 32'd1);
    idle(3);

    // 4: early in_last, then a clean frame, then clear
    for (int i = 0; i < 5; i++) send_s(FP[i], i == 4);
    chk("t4_err_set", 32'(err_frame_s), 32'd1);
    chk("t4_no_frame_done", 32'(frame_done_s), 32'd0);
    idle(2);
    push_t1();
    frame_t1(1'b0);
    chk("t4_clean_frame_done", 32'(frame_done_s), 32'd1);
    chk("t4_err_sticky", 32'(err_frame_s), 32'd1);
    err_clr_s = 1'b1; idle(1); err_clr_s = 1'b0;
    chk("t4_err_clr", 32'(err_frame_s), 32'd0);
    send_s(FP[0], 1'b0);
    err_clr_s = 1'b1;
    send_s(FP[1], 1'b1);
    err_clr_s = 1'b0;
    chk("t4_err_beats_clr", 32'(err_frame_s), 32'd1);
    err_clr_s = 1'b1; idle(1); err_clr_s = 1'b0;
    chk("t4_err_clr2", 32'(err_frame_s), 32'd0);
    idle(2);

    // 5: reset mid-frame, then a clean frame
    q_s.push_back(exp_t'{data: T1[0], addr: 13'd0, last: 1'b0});
    q_s.push_back(exp_t'{data: T1[1], addr: 13'd1, last: 1'b0});
    for (int i = 0; i < 10; i++) send_s(FP[i], 1'b0);
    idle(1);
    reset = 1'b0;
    idle(2);
    chk("t5_rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    chk("t5_rst_out_addr", 32'(bus_s.out_addr), 32'd0);
    chk("t5_rst_frame_done", 32'(frame_done_s), 32'd0);
    reset = 1'b1;
    idle(1);
    push_t1();
    frame_t1(1'b0);
    chk("t5_frame_done", 32'(frame_done_s), 32'd1);
    chk("t5_err_frame", 32'(err_frame_s), 32'd0);
    idle(3);

    // 6: 84x84 default map, two back-to-back frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 84*84; i++) fr[i] = 16'((i * 37 + f * 1013) & 16'hFFFF);
      for (int pr = 0; pr < 42; pr++) begin
        for (int pc = 0; pc < 42; pc++) begin
          logic [15:0] m, v;
          int a;
          m = 16'h0000;
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              v = relu_m(fr[(2*pr + dr) * 84 + 2*pc + dc]);
              if (v > m) m = v;
            end
          end
          a = pr * 42 + pc;
          q_b.push_back(exp_t'{data: m, addr: 13'(a), last: (a == 1763)});
        end
      end
      for (int i = 0; i < 84*84; i++) begin
        send_b(fr[i], i == 84*84 - 1);
        if (i == 84*84 - 1) chk("t6_frame_done", 32'(frame_done_b), 32'd1);
      end
    end
    idle(5);
    chk("t6_err_frame", 32'(err_frame_b), 32'd0);
    chk("small_queue_drained", 32'(q_s.size()), 32'd0);
    chk("big_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
